// File: rtl/hsv_core_branch_writeback.sv
// ============================================================================
// hsv_core_branch_writeback
// ----------------------------------------------------------------------------
// Final stage of the branch unit. Takes the resolved condition/target result
// from the previous stage, builds the link-register writeback and the
// instruction-address-misaligned exception for commit, and raises a held
// front-end redirect once commit has accepted a correctly aligned taken
// branch.
//
// Optional feature macro: HSV_BRANCH_PERF_EN
//   defined   : two COUNTER_WIDTH retire counters (all branches, taken ones)
//   undefined : counters absent, perf outputs tied to zero
//
// Parameters
//   COUNTER_WIDTH     width of the performance counters
//
// Ports
//   clk_core          core clock
//   rst_core          synchronous active-high reset
//   flush_req         pipeline flush, drops a held (unaccepted) result
//   valid_i           upstream result valid
//   in_pc             branch instruction PC
//   in_taken          branch resolved taken
//   in_target         computed target address
//   in_link           instruction writes rd (JAL/JALR)
//   in_rd             destination register index
//   stall_o           upstream must hold its outputs
//   valid_o           result valid toward commit
//   ready_i           commit accepts the result
//   out_rd            destination register
//   out_rd_we         rd write enable
//   out_rd_value      link value (pc + 4)
//   out_exception     instruction-address-misaligned trap
//   out_tval          faulting target address
//   redirect_valid_o  front-end redirect request (held until ack)
//   redirect_pc_o     redirect address
//   redirect_ack_i    front end accepted the redirect
//   perf_branches_o   retired branches
//   perf_taken_o      retired taken branches
// ============================================================================
module hsv_core_branch_writeback #(
  parameter int COUNTER_WIDTH = 32
) (
  input  logic                     clk_core,
  input  logic                     rst_core,
  input  logic                     flush_req,
  input  logic                     valid_i,
  input  logic [31:0]              in_pc,
  input  logic                     in_taken,
  input  logic [31:0]              in_target,
  input  logic                     in_link,
  input  logic [4:0]               in_rd,
  output logic                     stall_o,
  output logic                     valid_o,
  input  logic                     ready_i,
  output logic [4:0]               out_rd,
  output logic                     out_rd_we,
  output logic [31:0]              out_rd_value,
  output logic                     out_exception,
  output logic [31:0]              out_tval,
  output logic                     redirect_valid_o,
  output logic [31:0]              redirect_pc_o,
  input  logic                     redirect_ack_i,
  output logic [COUNTER_WIDTH-1:0] perf_branches_o,
  output logic [COUNTER_WIDTH-1:0] perf_taken_o
);

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_REDIRECT = 1'b1
  } state_e;

  state_e      state_q, state_d;

  logic        valid_q, valid_d;
  logic [4:0]  rd_q, rd_d;
  logic        rd_we_q, rd_we_d;
  logic [31:0] rd_value_q, rd_value_d;
  logic        exception_q, exception_d;
  logic [31:0] tval_q, tval_d;
  logic        redir_flag_q, redir_flag_d;
  logic [31:0] redir_target_q, redir_target_d;
  logic        redirect_valid_q, redirect_valid_d;
  logic [31:0] redirect_pc_q, redirect_pc_d;

  logic        stall;
  logic        accept;
  logic        handshake;
  logic        misaligned;

  // Handshake qualifiers. A flush in the same cycle as valid_i blocks the
  // capture so a killed instruction never reaches commit. The REDIRECT state
  // stalls upstream because anything arriving now is on the wrong path.
  always_comb begin
    stall      = (valid_q & ~ready_i) | (state_q == ST_REDIRECT);
    handshake  = valid_q & ready_i;
    accept     = valid_i & ~stall & ~flush_req;
    misaligned = in_taken & (in_target[1:0] != 2'b00);
  end

  // Result register. Fields only change on accept, so they stay stable while
  // commit back-pressures. valid drops on handshake or flush unless a new
  // result is captured in the same cycle (flush and accept are exclusive).
  always_comb begin
    valid_d        = valid_q;
    rd_d           = rd_q;
    rd_we_d        = rd_we_q;
    rd_value_d     = rd_value_q;
    exception_d    = exception_q;
    tval_d         = tval_q;
    redir_flag_d   = redir_flag_q;
    redir_target_d = redir_target_q;
    if (accept) begin
      valid_d        = 1'b1;
      rd_d           = in_rd;
      rd_we_d        = in_link & ~misaligned & (in_rd != 5'd0);
      rd_value_d     = in_pc + 32'd4;
      exception_d    = misaligned;
      tval_d         = misaligned ? in_target : 32'd0;
      redir_flag_d   = in_taken & ~misaligned;
      redir_target_d = in_target;
    end else if (handshake || flush_req) begin
      valid_d = 1'b0;
    end
  end

  // Redirect FSM next state. The redirect is launched by the commit
  // handshake itself, so a flush arriving in that same cycle cannot cancel
  // it. Once active, only the front-end ack leaves REDIRECT. A result that
  // was accepted alongside the launching handshake is younger than the taken
  // branch and therefore wrong-path; its own redirect flag is not honoured.
  always_comb begin
    state_d          = state_q;
    redirect_valid_d = redirect_valid_q;
    redirect_pc_d    = redirect_pc_q;
    case (state_q)
      ST_IDLE: begin
        if (handshake && redir_flag_q) begin
          state_d          = ST_REDIRECT;
          redirect_valid_d = 1'b1;
          redirect_pc_d    = redir_target_q;
        end
      end
      ST_REDIRECT: begin
        if (redirect_ack_i) begin
          state_d          = ST_IDLE;
          redirect_valid_d = 1'b0;
          redirect_pc_d    = 32'd0;
        end
      end
      default: begin
        state_d          = ST_IDLE;
        redirect_valid_d = 1'b0;
        redirect_pc_d    = 32'd0;
      end
    endcase
  end

  // State and registered outputs, all cleared by the synchronous reset.
  always_ff @(posedge clk_core) begin
    if (rst_core) begin
      state_q          <= ST_IDLE;
      valid_q          <= 1'b0;
      rd_q             <= 5'd0;
      rd_we_q          <= 1'b0;
      rd_value_q       <= 32'd0;
      exception_q      <= 1'b0;
      tval_q           <= 32'd0;
      redir_flag_q     <= 1'b0;
      redir_target_q   <= 32'd0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= 32'd0;
    end else begin
      state_q          <= state_d;
      valid_q          <= valid_d;
      rd_q             <= rd_d;
      rd_we_q          <= rd_we_d;
      rd_value_q       <= rd_value_d;
      exception_q      <= exception_d;
      tval_q           <= tval_d;
      redir_flag_q     <= redir_flag_d;
      redir_target_q   <= redir_target_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
    end
  end

`ifdef HSV_BRANCH_PERF_EN
  logic                     taken_flag_q, taken_flag_d;
  logic [COUNTER_WIDTH-1:0] perf_branches_q, perf_branches_d;
  logic [COUNTER_WIDTH-1:0] perf_taken_q, perf_taken_d;

  // Retire counters advance on the commit handshake only, so flushed results
  // are never counted. Taken includes misaligned targets; both wrap freely.
  always_comb begin
    taken_flag_d    = accept ? in_taken : taken_flag_q;
    perf_branches_d = perf_branches_q;
    perf_taken_d    = perf_taken_q;
    if (handshake) begin
      perf_branches_d = perf_branches_q + COUNTER_WIDTH'(1);
      if (taken_flag_q) begin
        perf_taken_d = perf_taken_q + COUNTER_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk_core) begin
    if (rst_core) begin
      taken_flag_q    <= 1'b0;
      perf_branches_q <= '0;
      perf_taken_q    <= '0;
    end else begin
      taken_flag_q    <= taken_flag_d;
      perf_branches_q <= perf_branches_d;
      perf_taken_q    <= perf_taken_d;
    end
  end

  assign perf_branches_o = perf_branches_q;
  assign perf_taken_o    = perf_taken_q;
`else
  assign perf_branches_o = '0;
  assign perf_taken_o    = '0;
`endif

  assign stall_o          = stall;
  assign valid_o          = valid_q;
  assign out_rd           = rd_q;
  assign out_rd_we        = rd_we_q;
  assign out_rd_value     = rd_value_q;
  assign out_exception    = exception_q;
  assign out_tval         = tval_q;
  assign redirect_valid_o = redirect_valid_q;
  assign redirect_pc_o    = redirect_pc_q;

endmodule

// File: tb/tb_hsv_core_branch_writeback.sv
// ============================================================================
// tb_hsv_core_branch_writeback
// ----------------------------------------------------------------------------
// Self-checking bench for hsv_core_branch_writeback (COUNTER_WIDTH = 4).
// Directed scenarios followed by a randomized run against a transaction-level
// reference model of the writeback stage.
// ============================================================================
module tb_hsv_core_branch_writeback;

  localparam int CW = 4;

  logic          clk;
  logic          rst;
  logic          flush_req;
  logic          valid_i;
  logic [31:0]   in_pc;
  logic          in_taken;
  logic [31:0]   in_target;
  logic          in_link;
  logic [4:0]    in_rd;
  logic          stall_o;
  logic          valid_o;
  logic          ready_i;
  logic [4:0]    out_rd;
  logic          out_rd_we;
  logic [31:0]   out_rd_value;
  logic          out_exception;
  logic [31:0]   out_tval;
  logic          redirect_valid_o;
  logic [31:0]   redirect_pc_o;
  logic          redirect_ack_i;
  logic [CW-1:0] perf_branches_o;
  logic [CW-1:0] perf_taken_o;

  int n_compared;
  int n_mismatched;

  hsv_core_branch_writeback #(.COUNTER_WIDTH(CW)) dut (
    .clk_core        (clk),
    .rst_core        (rst),
    .flush_req       (flush_req),
    .valid_i         (valid_i),
    .in_pc           (in_pc),
    .in_taken        (in_taken),
    .in_target       (in_target),
    .in_link         (in_link),
    .in_rd           (in_rd),
    .stall_o         (stall_o),
    .valid_o         (valid_o),
    .ready_i         (ready_i),
    .out_rd          (out_rd),
    .out_rd_we       (out_rd_we),
    .out_rd_value    (out_rd_value),
    .out_exception   (out_exception),
    .out_tval        (out_tval),
    .redirect_valid_o(redirect_valid_o),
    .redirect_pc_o   (redirect_pc_o),
    .redirect_ack_i  (redirect_ack_i),
    .perf_branches_o (perf_branches_o),
    .perf_taken_o    (perf_taken_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Transaction-level reference model
  typedef struct packed {
    logic [4:0]  rd;
    logic        we;
    logic [31:0] val;
    logic        exc;
    logic [31:0] tval;
    logic        redir;
    logic [31:0] tgt;
    logic        taken;
  } res_t;

  res_t        m_res;
  logic        m_valid;
  logic        m_redir;
  logic [31:0] m_redir_pc;
  int          m_branches;
  int          m_taken;

  function automatic res_t predict(logic [31:0] pc, logic taken, logic [31:0] tgt,
                                   logic link, logic [4:0] rd);
    res_t r;
    logic mis;
    mis     = taken && ((tgt % 4) != 0);
    r.rd    = rd;
    r.val   = pc + 32'd4;
    r.we    = link && !mis && (rd != 5'd0);
    r.exc   = mis;
    r.tval  = mis ? tgt : 32'd0;
    r.redir = taken && !mis;
    r.tgt   = tgt;
    r.taken = taken;
    return r;
  endfunction

  function automatic logic [CW-1:0] exp_perf(int cnt);
`ifdef HSV_BRANCH_PERF_EN
    return CW'(cnt % (1 << CW));
`else
    return CW'(0 * cnt);
`endif
  endfunction

  task automatic model_step();
    logic ms, hs, acc;
    if (rst) begin
      m_res = '0; m_valid = 1'b0; m_redir = 1'b0; m_redir_pc = 32'd0;
      m_branches = 0; m_taken = 0;
      return;
    end
    ms  = (m_valid && !ready_i) || m_redir;
    hs  = m_valid && ready_i;
    acc = valid_i && !ms && !flush_req;
    if (hs) begin
      m_branches++;
      if (m_res.taken) m_taken++;
    end
    if (m_redir) begin
      if (redirect_ack_i) begin m_redir = 1'b0; m_redir_pc = 32'd0; end
    end else if (hs && m_res.redir) begin
      m_redir = 1'b1; m_redir_pc = m_res.tgt;
    end
    if (acc) begin
      m_res   = predict(in_pc, in_taken, in_target, in_link, in_rd);
      m_valid = 1'b1;
    end else if (hs || flush_req) begin
      m_valid = 1'b0;
    end
  endtask

  // Advance model and DUT by one clock; inputs stay stable across the edge.
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_item(logic [31:0] pc, logic taken, logic [31:0] tgt,
                            logic link, logic [4:0] rd);
    valid_i = 1'b1; in_pc = pc; in_taken = taken; in_target = tgt;
    in_link = link; in_rd = rd;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush_req = 1'b0; valid_i = 1'b0; in_pc = 32'd0; in_taken = 1'b0;
    in_target = 32'd0; in_link = 1'b0; in_rd = 5'd0; ready_i = 1'b0; redirect_ack_i = 1'b0;
    tick(); tick();
    rst = 1'b0;
    #1;
    n_compared++; if (valid_o !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_valid: got %b want 0", valid_o); end
    n_compared++; if (stall_o !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_stall: got %b want 0", stall_o); end
    n_compared++; if (redirect_valid_o !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_redirect: got %b want 0", redirect_valid_o); end
    n_compared++; if ({out_rd, out_rd_we, out_rd_value, out_exception, out_tval, redirect_pc_o} !== '0) begin n_mismatched++; $display("[TB] FAIL reset_fields: rd=%h we=%b val=%h exc=%b tval=%h rpc=%h want all 0", out_rd, out_rd_we, out_rd_value, out_exception, out_tval, redirect_pc_o); end
    n_compared++; if ({perf_branches_o, perf_taken_o} !== '0) begin n_mismatched++; $display("[TB] FAIL reset_perf: got %h/%h want 0/0", perf_branches_o, perf_taken_o); end
  endtask

  task automatic test_not_taken();
    ready_i = 1'b1;
    drive_item(32'h100, 1'b0, 32'h500, 1'b0, 5'd3);
    tick();
    valid_i = 1'b0;
    n_compared++; if (valid_o !== 1'b1) begin n_mismatched++; $display("[TB] FAIL nt_valid: got %b want 1", valid_o); end
    n_compared++; if (out_rd_we !== 1'b0) begin n_mismatched++; $display("[TB] FAIL nt_we: got %b want 0", out_rd_we); end
    n_compared++; if (out_exception !== 1'b0) begin n_mismatched++; $display("[TB] FAIL nt_exc: got %b want 0", out_exception); end
    n_compared++; if (out_rd_value !== 32'h104) begin n_mismatched++; $display("[TB] FAIL nt_value: got %h want 00000104", out_rd_value); end
    tick();
    n_compared++; if (valid_o !== 1'b0) begin n_mismatched++; $display("[TB] FAIL nt_drain: got %b want 0", valid_o); end
    n_compared++; if (redirect_valid_o !== 1'b0) begin n_mismatched++; $display("[TB] FAIL nt_redirect: got %b want 0", redirect_valid_o); end
    // PC wrap on the link value
    drive_item(32'hFFFF_FFFC, 1'b0, 32'h0, 1'b1, 5'd4);
    tick();
    valid_i = 1'b0;
    n_compared++; if (out_rd_value !== 32'h0) begin n_mismatched++; $display("[TB] FAIL pc_wrap: got %h want 00000000", out_rd_value); end
    n_compared++; if (out_rd_we !== 1'b1) begin n_mismatched++; $display("[TB] FAIL pc_wrap_we: got %b want 1", out_rd_we); end
    tick();
  endtask

  task automatic test_jal();
    ready_i = 1'b1;
    drive_item(32'h200, 1'b1, 32'h340, 1'b1, 5'd1);
    tick();
    valid_i = 1'b0;
    n_compared++; if (out_rd_value !== 32'h204) begin n_mismatched++; $display("[TB] FAIL jal_value: got %h want 00000204", out_rd_value); end
    n_compared++; if (out_rd_we !== 1'b1) begin n_mismatched++; $display("[TB] FAIL jal_we: got %b want 1", out_rd_we); end
    n_compared++; if (out_rd !== 5'd1) begin n_mismatched++; $display("[TB] FAIL jal_rd: got %0d want 1", out_rd); end
    n_compared++; if (redirect_valid_o !== 1'b0) begin n_mismatched++; $display("[TB] FAIL jal_early_redirect: got %b want 0", redirect_valid_o); end
    tick();
    n_compared++; if (redirect_valid_o !== 1'b1) begin n_mismatched++; $display("[TB] FAIL jal_redirect: got %b want 1", redirect_valid_o); end
    n_compared++; if (redirect_pc_o !== 32'h340) begin n_mismatched++; $display("[TB] FAIL jal_redirect_pc: got %h want 00000340", redirect_pc_o); end
    n_compared++; if (stall_o !== 1'b1) begin n_mismatched++; $display("[TB] FAIL jal_stall: got %b want 1", stall_o); end
    tick();
    n_compared++; if (redirect_valid_o !== 1'b1 || redirect_pc_o !== 32'h340) begin n_mismatched++; $display("[TB] FAIL jal_hold: got %b/%h want 1/00000340", redirect_valid_o, redirect_pc_o); end
    redirect_ack_i = 1'b1;
    #1;
    n_compared++; if (stall_o !== 1'b1) begin n_mismatched++; $display("[TB] FAIL jal_stall_ack: got %b want 1", stall_o); end
    tick();
    redirect_ack_i = 1'b0;
    #1;
    n_compared++; if (redirect_valid_o !== 1'b0) begin n_mismatched++; $display("[TB] FAIL jal_ack: got %b want 0", redirect_valid_o); end
    n_compared++; if (stall_o !== 1'b0) begin n_mismatched++; $display("[TB] FAIL jal_unstall: got %b want 0", stall_o); end
  endtask

  task automatic test_misaligned();
    ready_i = 1'b1;
    drive_item(32'h300, 1'b1, 32'h342, 1'b1, 5'd5);
    tick();
    valid_i = 1'b0;
    n_compared++; if (out_exception !== 1'b1) begin n_mismatched++; $display("[TB] FAIL mis_exc: got %b want 1", out_exception); end
    n_compared++; if (out_tval !== 32'h342) begin n_mismatched++; $display("[TB] FAIL mis_tval: got %h want 00000342", out_tval); end
    n_compared++; if (out_rd_we !== 1'b0) begin n_mismatched++; $display("[TB] FAIL mis_we: got %b want 0", out_rd_we); end
    tick();
    n_compared++; if (redirect_valid_o !== 1'b0) begin n_mismatched++; $display("[TB] FAIL mis_redirect: got %b want 0", redirect_valid_o); end
  endtask

  task automatic test_backpressure();
    ready_i = 1'b0;
    drive_item(32'h400, 1'b0, 32'h0, 1'b1, 5'd7);
    tick();
    drive_item(32'h500, 1'b0, 32'h0, 1'b1, 5'd9);
    for (int i = 0; i < 3; i++) begin
      #1;
      n_compared++; if (stall_o !== 1'b1) begin n_mismatched++; $display("[TB] FAIL bp_stall%0d: got %b want 1", i, stall_o); end
      n_compared++; if (valid_o !== 1'b1 || out_rd !== 5'd7 || out_rd_value !== 32'h404) begin n_mismatched++; $display("[TB] FAIL bp_hold%0d: got v=%b rd=%0d val=%h want 1/7/00000404", i, valid_o, out_rd, out_rd_value); end
      tick();
    end
    ready_i = 1'b1;
    #1;
    n_compared++; if (stall_o !== 1'b0) begin n_mismatched++; $display("[TB] FAIL bp_release: got %b want 0", stall_o); end
    tick();
    valid_i = 1'b0;
    n_compared++; if (valid_o !== 1'b1 || out_rd !== 5'd9 || out_rd_value !== 32'h504) begin n_mismatched++; $display("[TB] FAIL bp_next: got v=%b rd=%0d val=%h want 1/9/00000504", valid_o, out_rd, out_rd_value); end
    tick();
    n_compared++; if (valid_o !== 1'b0) begin n_mismatched++; $display("[TB] FAIL bp_drain: got %b want 0", valid_o); end
  endtask

  task automatic test_flush();
    // held, unaccepted result dropped: no redirect
    ready_i = 1'b0;
    drive_item(32'h700, 1'b1, 32'h600, 1'b0, 5'd0);
    tick();
    valid_i = 1'b0; flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
    n_compared++; if (valid_o !== 1'b0) begin n_mismatched++; $display("[TB] FAIL fl_drop: got %b want 0", valid_o); end
    ready_i = 1'b1;
    tick(); tick();
    n_compared++; if (redirect_valid_o !== 1'b0) begin n_mismatched++; $display("[TB] FAIL fl_no_redirect: got %b want 0", redirect_valid_o); end
    // valid_i together with flush is not captured
    drive_item(32'hA00, 1'b0, 32'h0, 1'b1, 5'd2);
    flush_req = 1'b1;
    tick();
    valid_i = 1'b0; flush_req = 1'b0;
    n_compared++; if (valid_o !== 1'b0) begin n_mismatched++; $display("[TB] FAIL fl_capture: got %b want 0", valid_o); end
    // handshake together with flush still redirects
    drive_item(32'h900, 1'b1, 32'h800, 1'b0, 5'd0);
    tick();
    valid_i = 1'b0; flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
    n_compared++; if (valid_o !== 1'b0) begin n_mismatched++; $display("[TB] FAIL fl_hs_valid: got %b want 0", valid_o); end
    n_compared++; if (redirect_valid_o !== 1'b1 || redirect_pc_o !== 32'h800) begin n_mismatched++; $display("[TB] FAIL fl_hs_redirect: got %b/%h want 1/00000800", redirect_valid_o, redirect_pc_o); end
    // flush during REDIRECT does not cancel it
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
    n_compared++; if (redirect_valid_o !== 1'b1) begin n_mismatched++; $display("[TB] FAIL fl_redirect_kept: got %b want 1", redirect_valid_o); end
    redirect_ack_i = 1'b1;
    tick();
    redirect_ack_i = 1'b0;
    n_compared++; if (redirect_valid_o !== 1'b0) begin n_mismatched++; $display("[TB] FAIL fl_redirect_ack: got %b want 0", redirect_valid_o); end
  endtask

  task automatic test_perf_wrap();
    logic [CW-1:0] want;
    rst = 1'b1; tick(); rst = 1'b0;
    ready_i = 1'b1;
    for (int i = 0; i < 17; i++) begin
      drive_item(32'h1000 + 32'(i * 4), 1'b1, 32'h2002, 1'b1, 5'd6);
      tick();
    end
    valid_i = 1'b0;
    tick();
`ifdef HSV_BRANCH_PERF_EN
    want = CW'(1);
`else
    want = '0;
`endif
    n_compared++; if (perf_branches_o !== want) begin n_mismatched++; $display("[TB] FAIL perf_branches_wrap: got %0d want %0d", perf_branches_o, want); end
    n_compared++; if (perf_taken_o !== want) begin n_mismatched++; $display("[TB] FAIL perf_taken_wrap: got %0d want %0d", perf_taken_o, want); end
    n_compared++; if (redirect_valid_o !== 1'b0) begin n_mismatched++; $display("[TB] FAIL perf_no_redirect: got %b want 0", redirect_valid_o); end
  endtask

  task automatic test_reset_mid_redirect();
    ready_i = 1'b1;
    drive_item(32'hB00, 1'b1, 32'hC00, 1'b1, 5'd8);
    tick();
    drive_item(32'hB04, 1'b0, 32'h0, 1'b1, 5'd9);
    tick();
    valid_i = 1'b0;
    n_compared++; if (redirect_valid_o !== 1'b1 || valid_o !== 1'b1) begin n_mismatched++; $display("[TB] FAIL rr_setup: got redir=%b valid=%b want 1/1", redirect_valid_o, valid_o); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    n_compared++; if ({valid_o, stall_o, redirect_valid_o, redirect_pc_o, out_rd, out_rd_we, out_rd_value, out_exception, out_tval, perf_branches_o, perf_taken_o} !== '0) begin n_mismatched++; $display("[TB] FAIL rr_outputs: v=%b s=%b rv=%b rpc=%h rd=%h we=%b val=%h exc=%b tval=%h pb=%h pt=%h want all 0", valid_o, stall_o, redirect_valid_o, redirect_pc_o, out_rd, out_rd_we, out_rd_value, out_exception, out_tval, perf_branches_o, perf_taken_o); end
  endtask

  task automatic test_random();
    logic        exp_stall;
    logic [31:0] tgt;
    for (int c = 0; c < 400; c++) begin
      tgt = $urandom;
      if ($urandom_range(0, 2) != 0) tgt[1:0] = 2'b00;
      valid_i        = ($urandom_range(0, 3) != 0);
      in_pc          = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
      in_taken       = $urandom_range(0, 1) == 1;
      in_target      = tgt;
      in_link        = $urandom_range(0, 1) == 1;
      in_rd          = 5'($urandom_range(0, 31));
      ready_i        = ($urandom_range(0, 9) < 7);
      flush_req      = ($urandom_range(0, 9) == 0);
      redirect_ack_i = ($urandom_range(0, 9) < 4);
      #1;
      exp_stall = (m_valid && !ready_i) || m_redir;
      n_compared++; if (stall_o !== exp_stall) begin n_mismatched++; $display("[TB] FAIL rnd_stall c%0d: got %b want %b", c, stall_o, exp_stall); end
      tick();
      n_compared++; if (valid_o !== m_valid) begin n_mismatched++; $display("[TB] FAIL rnd_valid c%0d: got %b want %b", c, valid_o, m_valid); end
      n_compared++; if (redirect_valid_o !== m_redir) begin n_mismatched++; $display("[TB] FAIL rnd_redirect c%0d: got %b want %b", c, redirect_valid_o, m_redir); end
      if (m_redir) begin
        n_compared++; if (redirect_pc_o !== m_redir_pc) begin n_mismatched++; $display("[TB] FAIL rnd_redirect_pc c%0d: got %h want %h", c, redirect_pc_o, m_redir_pc); end
      end
      if (m_valid) begin
        n_compared++; if ({out_rd, out_rd_we, out_rd_value, out_exception, out_tval} !== {m_res.rd, m_res.we, m_res.val, m_res.exc, m_res.tval}) begin n_mismatched++; $display("[TB] FAIL rnd_fields c%0d: got rd=%0d we=%b val=%h exc=%b tval=%h want rd=%0d we=%b val=%h exc=%b tval=%h", c, out_rd, out_rd_we, out_rd_value, out_exception, out_tval, m_res.rd, m_res.we, m_res.val, m_res.exc, m_res.tval); end
      end
      n_compared++; if (perf_branches_o !== exp_perf(m_branches) || perf_taken_o !== exp_perf(m_taken)) begin n_mismatched++; $display("[TB] FAIL rnd_perf c%0d: got %0d/%0d want %0d/%0d", c, perf_branches_o, perf_taken_o, exp_perf(m_branches), exp_perf(m_taken)); end
    end
    valid_i = 1'b0; flush_req = 1'b0; redirect_ack_i = 1'b0;
  endtask

  initial begin
    n_compared   = 0;
    n_mismatched = 0;
    m_res = '0; m_valid = 1'b0; m_redir = 1'b0; m_redir_pc = 32'd0;
    m_branches = 0; m_taken = 0;
    test_reset();
    test_not_taken();
    test_jal();
    test_misaligned();
    test_backpressure();
    test_flush();
    test_perf_wrap();
    test_reset_mid_redirect();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/hsv_core_branch_writeback.md
Name: hsv_core_branch_writeback

Overview:
- Final stage of the branch unit.
- Consumes the registered condition/target results from the branch condition/target stage.
- Produces the link register writeback and flags misaligned-target exceptions toward commit.
- Issues a held front-end redirect request once commit accepts a taken branch.
- Back-pressures the upstream stage through stall_o.

Parameters:
COUNTER_WIDTH, 32, width of performance counters (used only with HSV_BRANCH_PERF_EN)

Ports:
clk_core  in  1  core clock
rst_core  in  1  synchronous active-high reset
flush_req  in  1  pipeline flush; kills the held result
valid_i  in  1  upstream result valid
in_pc  in  32  branch instruction PC
in_taken  in  1  branch resolved taken
in_target  in  32  computed target address
in_link  in  1  instruction writes rd (JAL/JALR)
in_rd  in  5  destination register index
stall_o  out  1  upstream must hold its outputs
valid_o  out  1  result valid to commit
ready_i  in  1  commit accepts result
out_rd  out  5  destination register
out_rd_we  out  1  rd write enable
out_rd_value  out  32  link value
out_exception  out  1  instruction-address-misaligned trap
out_tval  out  32  faulting target address
redirect_valid_o  out  1  front-end redirect request
redirect_pc_o  out  32  redirect address
redirect_ack_i  in  1  front end accepted redirect
perf_branches_o  out  COUNTER_WIDTH  retired branches (feature only)
perf_taken_o  out  COUNTER_WIDTH  retired taken branches (feature only)

Behaviour:
Reset values:
- rst_core (sync) forces every output to 0 and the FSM to IDLE.

Stall and accept:
- stall_o = (valid_o & ~ready_i) | (state == REDIRECT).
- Accept when valid_i & ~stall_o.
- Latency: accept at edge N gives valid_o at N+1.

Computation on accept:
- misaligned = in_taken & (in_target[1:0] != 0).
- out_rd = in_rd.
- out_rd_value = in_pc + 4, mod 2^32 (PC 0xFFFFFFFC wraps to 0).
- out_rd_we = in_link & ~misaligned & (in_rd != 0).
- out_exception = misaligned; out_tval = in_target when misaligned, else 0.
- Internal redirect flag = in_taken & ~misaligned; redirect target latched = in_target.

Output register:
- valid_o is cleared on handshake (valid_o & ready_i) unless a new accept occurs in the same cycle.
- Back-to-back accepts are allowed when ready_i = 1.
- While valid_o & ~ready_i, all out_* fields are held stable.

FSM (IDLE, REDIRECT):
- IDLE -> REDIRECT when a handshake completes with the redirect flag set.
- In REDIRECT: redirect_valid_o = 1; redirect_pc_o = latched target, held stable.
- REDIRECT -> IDLE on redirect_ack_i. Ack in the first REDIRECT cycle is legal.
- redirect_valid_o deasserts the cycle after ack.
- No accepts occur while in REDIRECT (stall_o high).

Flush:
- flush_req clears valid_o the next cycle. A held unaccepted result is dropped; no redirect and no counter update.
- flush_req does not cancel an active REDIRECT; only redirect_ack_i exits it.
- valid_i & flush_req in the same cycle: the result is not captured.
- Handshake & flush_req in the same cycle: the handshake counts, and the redirect is still issued.

Exceptions:
- A misaligned result never redirects; commit handles the trap.

Optional Feature:
Macro: HSV_BRANCH_PERF_EN

Defined:
- Two COUNTER_WIDTH counters increment on each commit handshake.
- perf_branches_o always increments; perf_taken_o increments when in_taken was set, including misaligned.
- Both counters wrap to 0 on overflow and reset to 0.

Undefined:
- Counters are not instantiated; both perf outputs are tied to 0.

Test Plan:
1. Not-taken branch: pc=0x100, taken=0, link=0, ready_i=1. Expect valid_o one cycle later, rd_we=0, exception=0, no redirect_valid_o.
2. JAL: pc=0x200, target=0x340, rd=1, link=1. Expect rd_value=0x204, rd_we=1. After handshake, redirect_valid_o=1 with redirect_pc_o=0x340 until ack. stall_o stays high until ack; ack gives IDLE next cycle.
3. Misaligned: taken=1, target=0x342. Expect exception=1, tval=0x342, rd_we=0, no redirect.
4. Backpressure: ready_i=0 for 3 cycles with valid_i=1. Expect stall_o=1, outputs stable. ready_i=1 then accepts the next item the same cycle.
5. flush_req while valid_o=1 and ready_i=0: valid_o=0 next cycle, no redirect. flush_req during REDIRECT: redirect_valid_o stays 1 until ack.
6. PERF_EN with COUNTER_WIDTH=4: 17 taken branches retired. Expect perf_branches_o=1 and perf_taken_o=1 (wrap). Reset mid-REDIRECT: all outputs 0 next cycle.
